// File: rtl/rgb_fade_pwm.sv
// rtl/rgb_fade_pwm.sv - three-channel PWM fade sequencer feeding the SB_RGBA_DRV RGBxPWM inputs
// Optional RGB_GAMMA_EN: compare against a registered squared level (one extra clk of level latency).
module rgb_fade_pwm #(
  parameter int PRESCALE    = 47,
  parameter int PWM_BITS    = 8,
  parameter int HOLD_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [3*PWM_BITS-1:0]   cfg_rgb,
  output logic                    busy,
  output logic                    frame_tick,
  output logic                    rgb0_pwm,
  output logic                    rgb1_pwm,
  output logic                    rgb2_pwm
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int HC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [HC_W-1:0]     HC_LAST = HC_W'(HOLD_FRAMES - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FADE  = 2'd1,
    HOLD  = 2'd2,
    DECAY = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                frame_tick_q, frame_tick_d;
  logic                active_q, active_d;
  logic [HC_W-1:0]     hold_q, hold_d;
  logic [PWM_BITS-1:0] level_q [3];
  logic [PWM_BITS-1:0] level_d [3];
  logic [PWM_BITS-1:0] target_q [3];
  logic [PWM_BITS-1:0] target_d [3];
  logic                pwm_q [3];
  logic                pwm_d [3];
  logic [PWM_BITS-1:0] toward [3];
  logic [PWM_BITS-1:0] decay [3];
  logic                all_eq;
  logic                decay_zero;
  logic                step;
  logic                tick;
  logic                xfer;

  assign step       = en && (presc_q == PS_LAST);
  assign tick       = en && frame_tick_q;
  // active_q keeps cfg_ready low while rst is asserted, even with en high
  assign cfg_ready  = en && active_q && ((state_q == IDLE) || (state_q == HOLD));
  assign xfer       = cfg_valid && cfg_ready;
  assign busy       = (state_q != IDLE);
  assign frame_tick = tick;
  assign rgb0_pwm   = pwm_q[0];
  assign rgb1_pwm   = pwm_q[1];
  assign rgb2_pwm   = pwm_q[2];

  always_comb begin : timebase_comb
    presc_d      = presc_q;
    cnt_d        = cnt_q;
    frame_tick_d = step && (cnt_q == CNT_MAX);
    active_d     = 1'b1;
    if (en) begin
      presc_d = step ? '0 : presc_q + 1'b1;
      if (step) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin : level_math_comb
    all_eq     = 1'b1;
    decay_zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      toward[i] = level_q[i];
      if (level_q[i] < target_q[i]) begin
        toward[i] = level_q[i] + 1'b1;
      end else if (level_q[i] > target_q[i]) begin
        toward[i] = level_q[i] - 1'b1;
      end
      decay[i] = (level_q[i] == '0) ? '0 : level_q[i] - 1'b1;
      if (level_q[i] != target_q[i]) begin
        all_eq = 1'b0;
      end
      if (decay[i] != '0) begin
        decay_zero = 1'b0;
      end
    end
  end

  always_comb begin : fsm_comb
    state_d  = state_q;
    hold_d   = hold_q;
    level_d  = level_q;
    target_d = target_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = FADE;
        end
      end
      FADE: begin
        if (tick) begin
          if (all_eq) begin
            state_d = HOLD;
            hold_d  = '0;
          end else begin
            level_d = toward;
          end
        end
      end
      HOLD: begin
        // a new target takes priority over hold expiry on the same edge
        if (xfer) begin
          state_d = FADE;
        end else if (tick) begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HC_LAST) begin
            state_d = DECAY;
          end
        end
      end
      DECAY: begin
        if (tick) begin
          level_d = decay;
          if (decay_zero) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (xfer) begin
      target_d[0] = cfg_rgb[3*PWM_BITS-1:2*PWM_BITS];
      target_d[1] = cfg_rgb[2*PWM_BITS-1:PWM_BITS];
      target_d[2] = cfg_rgb[PWM_BITS-1:0];
    end
  end

`ifdef RGB_GAMMA_EN
  logic [PWM_BITS-1:0]   gamma_q [3];
  logic [PWM_BITS-1:0]   gamma_d [3];
  logic [2*PWM_BITS-1:0] square [3];

  always_comb begin : gamma_comb
    for (int i = 0; i < 3; i++) begin
      square[i]  = {{PWM_BITS{1'b0}}, level_q[i]} * {{PWM_BITS{1'b0}}, level_q[i]};
      gamma_d[i] = PWM_BITS'(square[i] >> PWM_BITS);
      pwm_d[i]   = en && (cnt_q < gamma_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin : gamma_ff
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        gamma_q[i] <= '0;
      end
    end else begin
      gamma_q <= gamma_d;
    end
  end
`else
  always_comb begin : pwm_comb
    for (int i = 0; i < 3; i++) begin
      pwm_d[i] = en && (cnt_q < level_q[i]);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin : state_ff
    if (rst) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      cnt_q        <= '0;
      frame_tick_q <= 1'b0;
      active_q     <= 1'b0;
      hold_q       <= '0;
      for (int i = 0; i < 3; i++) begin
        level_q[i]  <= '0;
        target_q[i] <= '0;
        pwm_q[i]    <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      frame_tick_q <= frame_tick_d;
      active_q     <= active_d;
      hold_q       <= hold_d;
      level_q      <= level_d;
      target_q     <= target_d;
      pwm_q        <= pwm_d;
    end
  end

endmodule

// File: doc/rgb_fade_pwm.md
Name: rgb_fade_pwm

Overview:
- Three-channel PWM fade sequencer that drives the RGB0PWM/RGB1PWM/RGB2PWM inputs of the SB_RGBA_DRV LED driver.
- Clocked from the divided SB_HFOSC clock.
- Accepts a 24-bit target colour over a valid/ready handshake, ramps all channels toward it, holds, then decays to off.
- Sits between the clock-divider stage and the LED driver primitive.

Parameters:
PRESCALE, 47, clk cycles per PWM counter step (minimum 1)
PWM_BITS, 8, PWM counter and level width
HOLD_FRAMES, 64, PWM frames spent in HOLD before decay (minimum 1)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
en  input  1  run enable; low freezes all counters and the FSM
cfg_valid  input  1  target colour valid
cfg_ready  output  1  target colour accepted this cycle if cfg_valid
cfg_rgb  input  3*PWM_BITS  target levels {r,g,b}; r in the MSBs
busy  output  1  FSM not in IDLE
frame_tick  output  1  one-cycle pulse at PWM counter wrap
rgb0_pwm  output  1  red PWM to driver
rgb1_pwm  output  1  green PWM to driver
rgb2_pwm  output  1  blue PWM to driver

Behaviour:
- Reset (async, active-high): prescaler=0, PWM counter=0, levels=0, targets=0, hold count=0, state=IDLE. All outputs 0, including cfg_ready.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1.
  - Internal step pulse when the count equals PRESCALE-1; the count then wraps to 0.
- PWM counter:
  - PWM_BITS wide; increments on each step pulse; wraps from 2^PWM_BITS-1 to 0.
  - frame_tick is registered and asserts for exactly one clk on the cycle after the step that wraps the counter.
- PWM outputs:
  - Registered: pwm_x <= (cnt < level_x).
  - level=0 gives a constant-low output; level=max gives high for 255 of 256 steps.
  - One clk latency from counter to output.
- cfg_ready = en && (state==IDLE || state==HOLD). It is combinational from registered state.
- Transfer: cfg_valid && cfg_ready on a rising clk edge latches cfg_rgb into the target registers and sets state to FADE.
- FSM (evaluated on clk; levels change only on frame_tick):
  - IDLE: levels hold at 0; busy=0. Transfer -> FADE.
  - FADE: on each frame_tick, each level moves 1 toward its target (+1 or -1; no change if equal). On the first frame_tick where all levels equal their targets before the update -> HOLD, and the hold count clears.
  - HOLD: the hold count increments on each frame_tick. When it reaches HOLD_FRAMES-1 at a frame_tick -> DECAY. A transfer in HOLD aborts the hold -> FADE with the new target; levels move up or down from their current values.
  - DECAY: each level decrements by 1 per frame_tick (saturating at 0). On the frame_tick where all levels are 0 -> IDLE. cfg_ready=0 in this state.
- Target all-zero from IDLE: FADE -> HOLD on the first frame_tick -> DECAY -> IDLE; outputs stay low throughout.
- en=0:
  - Prescaler, PWM counter, hold count, levels and state freeze.
  - pwm outputs are forced to 0 on the next clk.
  - frame_tick=0; cfg_ready=0.
  - Resuming en continues from the frozen values.
- Simultaneous transfer and HOLD expiry on the same edge: the transfer wins -> FADE.
- Reset asserted mid-fade: all state clears immediately and asynchronously; outputs go 0 without waiting for a clk.

Optional Feature:
- Macro RGB_GAMMA_EN.
- Defined: the compare uses a gamma level g_x = (level_x*level_x) >> PWM_BITS, registered. This adds one extra clk of output latency (2 total). Nonzero levels below 16 yield g=0.
- Undefined: linear compare against level_x, 1 clk latency.
- FSM, handshake and frame_tick timing are identical in both builds.

Test Plan (PRESCALE=2, PWM_BITS=8, HOLD_FRAMES=4; frame = 512 clk):
- Reset mid-operation: assert rst while in FADE with levels around 40 -> all outputs 0 and busy=0 the same cycle with no clk edge; cfg_ready=1 one cycle after release with en=1.
- Frame timing: en=1, idle -> frame_tick pulses exactly 1 clk wide, every 512 clk; PWM outputs stay 0.
- Fade up: send cfg_rgb=0x030100 in IDLE -> red level reaches 3 after 3 frame_ticks and green reaches 1 after 1. HOLD is entered at frame 4; red is high 3 of every 256 steps (6 clk per frame) and blue is always low.
- Hold/decay: continuing from the fade-up case -> DECAY after 4 HOLD frames, then IDLE 3 frame_ticks later; busy falls with the transition to IDLE.
- Re-target in HOLD: in HOLD with red=3, send 0x010000 -> cfg_ready high, state=FADE, red decrements to 1 over 2 frames, then HOLD.
- en freeze: drop en for 1000 clk mid-FADE -> PWM outputs 0 after 1 clk, no frame_tick, level and counter unchanged. On resume, the next frame_tick arrives at the remaining count.
